bram_stream_writer: RTL

- Stream-to-BRAM loader that fills the node, weight and bias BRAMs which data_mover_bram later reads.
- Accepts a valid/ready stream of IN_DATA_WIDTH samples and packs consecutive pairs into one DWIDTH word.
- Writes each packed word sequentially into the one bank selected at start, through that BRAM's port A.
- Uses the same run/idle/done control style as data_mover_bram, so software can sequence load then compute.

---
 rtl/bram_stream_writer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bram_stream_writer.sv
// Stream-to-BRAM loader: packs pairs of stream samples into one word and writes
// them sequentially into the node, weight or bias bank selected at start.
module bram_stream_writer #(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 12,
    parameter int MEM_SIZE      = 4096,
    parameter int IN_DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_run,
    input  logic [CNT_BIT-1:0]       i_num_cnt,
    input  logic [1:0]               i_bank_sel,
    output logic                     o_idle,
    output logic                     o_write,
    output logic                     o_done,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [IN_DATA_WIDTH-1:0] s_data,
    output logic [AWIDTH-1:0]        addr_b0,
    output logic                     ce_b0,
    output logic                     we_b0,
    output logic [DWIDTH-1:0]        d_b0,
    output logic [AWIDTH-1:0]        addr_b1,
    output logic                     ce_b1,
    output logic                     we_b1,
    output logic [DWIDTH-1:0]        d_b1,
    output logic [AWIDTH-1:0]        addr_b2,
    output logic                     ce_b2,
    output logic                     we_b2,
    output logic [DWIDTH-1:0]        d_b2
);

    // A word must hold exactly two samples and the bank must fit the address space.
    if (DWIDTH != 2 * IN_DATA_WIDTH || MEM_SIZE > (1 << AWIDTH)) begin : g_param_check
        $error("bram_stream_writer: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_BIT-1:0] ONE = CNT_BIT'(1);

    state_t                   r_state;
    state_t                   w_next;
    logic [CNT_BIT-1:0]       r_num_cnt;
    logic [CNT_BIT-1:0]       r_word_idx;
    logic [1:0]               r_bank;
    logic                     r_half_valid;
    logic [IN_DATA_WIDTH-1:0] r_half;
    logic [AWIDTH-1:0]        r_addr [3];
    logic                     r_ce   [3];
    logic [DWIDTH-1:0]        r_d    [3];

    logic w_accept;
    logic w_word_done;
    logic w_last;

    assign w_accept    = (r_state == S_RUN) && s_valid;
    assign w_word_done = w_accept && r_half_valid;
    assign w_last      = w_word_done && (r_word_idx == r_num_cnt - ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_run) w_next = (i_num_cnt == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_idle  = (r_state == S_IDLE);
        o_write = (r_state == S_RUN);
        o_done  = (r_state == S_DONE);
        s_ready = (r_state == S_RUN);
    end

    // ce/we pulse for one cycle per packed word; addr/d hold their last value otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_cnt    <= '0;
            r_word_idx   <= '0;
            r_bank       <= '0;
            r_half_valid <= 1'b0;
            r_half       <= '0;
            for (int b = 0; b < 3; b++) begin
                r_addr[b] <= '0;
                r_ce[b]   <= 1'b0;
                r_d[b]    <= '0;
            end
        end else begin
            for (int b = 0; b < 3; b++) r_ce[b] <= 1'b0;
            if (r_state == S_IDLE && i_run) begin
                r_num_cnt    <= i_num_cnt;
                r_bank       <= i_bank_sel;
                r_word_idx   <= '0;
                r_half_valid <= 1'b0;
            end
            if (w_accept) begin
                if (!r_half_valid) begin
                    r_half       <= s_data;
                    r_half_valid <= 1'b1;
                end else begin
                    r_half_valid <= 1'b0;
                    r_word_idx   <= r_word_idx + ONE;
                    for (int b = 0; b < 3; b++) begin
                        if (r_bank == 2'(b)) begin
                            r_ce[b]   <= 1'b1;
                            r_addr[b] <= r_word_idx[AWIDTH-1:0];
                            r_d[b]    <= {r_half, s_data};
                        end
                    end
                end
            end
        end
    end

    assign addr_b0 = r_addr[0];
    assign ce_b0   = r_ce[0];
    assign we_b0   = r_ce[0];
    assign d_b0    = r_d[0];
    assign addr_b1 = r_addr[1];
    assign ce_b1   = r_ce[1];
    assign we_b1   = r_ce[1];
    assign d_b1    = r_d[1];
    assign addr_b2 = r_addr[2];
    assign ce_b2   = r_ce[2];
    assign we_b2   = r_ce[2];
    assign d_b2    = r_d[2];

endmodule
